// File: rtl/line_buffer_bram_xppc.sv
// Cascaded multi-line BRAM line buffer for the Xppc stereo pipeline: NUM_LINES column-aligned taps per beat.
// Define LINE_BUFFER_BORDER_REPLICATE_EN to replace invalid taps with the top valid row of the frame.
`timescale 1ns/1ps
module line_buffer_bram_xppc #(
    parameter int DATA_WIDTH            = 97,
    parameter int MAX_SAMPLES_PER_CLOCK = 4,
    parameter int MAX_PIXELS_PER_LINE   = 2048,
    parameter int NUM_LINES             = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ce,
    input  logic                            sof,
    input  logic                            tlast,
    input  logic [DATA_WIDTH-1:0]           din,
    output logic [NUM_LINES*DATA_WIDTH-1:0] dout_taps,
    output logic [NUM_LINES-1:0]            tap_valid,
    output logic                            dout_valid,
    output logic                            dout_sof,
    output logic                            dout_tlast,
    output logic                            ovf_err
);
    localparam int DEPTH  = MAX_PIXELS_PER_LINE / MAX_SAMPLES_PER_CLOCK;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MEM_W  = (NUM_LINES - 1) * DATA_WIDTH;
    localparam int LF_W   = $clog2(NUM_LINES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [LF_W-1:0]   LF_MAX    = LF_W'(NUM_LINES - 1);

    function automatic logic [LF_W-1:0] sat_inc(input logic [LF_W-1:0] lf);
        sat_inc = (lf == LF_MAX) ? lf : lf + LF_W'(1);
    endfunction

    function automatic logic [NUM_LINES-1:0] valid_mask(input logic [LF_W-1:0] lf);
        valid_mask = '0;
        for (int k = 0; k < NUM_LINES; k++) valid_mask[k] = (k <= int'(lf));
    endfunction

    logic [ADDR_W-1:0]              position_p0;
    logic [ADDR_W-1:0]              rd_addr_p0;
    logic [LF_W-1:0]                lines_filled_p0;
    logic [LF_W-1:0]                lf_base_p0;
    logic [ADDR_W-1:0]              wr_addr_p1;
    logic [DATA_WIDTH-1:0]          din_p1;
    logic [MEM_W-1:0]               rd_p1;
    logic [MEM_W-1:0]               wdata_p1;
    logic                           vld_p1;
    logic [NUM_LINES-1:0]           tap_valid_p1;
    logic [NUM_LINES*DATA_WIDTH-1:0] taps_p1;
    logic [MEM_W-1:0]               mem [DEPTH];

    // stage p0: the sof beat always lands on column 0 and restarts the fill count
    assign rd_addr_p0 = sof ? '0 : position_p0;
    assign lf_base_p0 = sof ? '0 : lines_filled_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            position_p0     <= '0;
            lines_filled_p0 <= '0;
            ovf_err         <= 1'b0;
            wr_addr_p1      <= '0;
            vld_p1          <= 1'b0;
            tap_valid_p1    <= '0;
            dout_sof        <= 1'b0;
            dout_tlast      <= 1'b0;
        end else begin
            vld_p1 <= ce;
            if (ce) begin
                wr_addr_p1      <= rd_addr_p0;
                dout_sof        <= sof;
                dout_tlast      <= tlast;
                tap_valid_p1    <= valid_mask(lf_base_p0);
                lines_filled_p0 <= tlast ? sat_inc(lf_base_p0) : lf_base_p0;
                if (tlast)
                    position_p0 <= '0;
                else if (rd_addr_p0 == LAST_ADDR)
                    position_p0 <= LAST_ADDR;
                else
                    position_p0 <= rd_addr_p0 + ADDR_W'(1);
                if (sof)
                    ovf_err <= 1'b0;
                else if (!tlast && position_p0 == LAST_ADDR)
                    ovf_err <= 1'b1;
            end
        end
    end

    // stage p1: each slot shifts one line older as the previous beat is written back
    generate
        if (NUM_LINES > 2) begin : g_shift
            assign wdata_p1 = {rd_p1[MEM_W-DATA_WIDTH-1:0], din_p1};
        end else begin : g_single
            assign wdata_p1 = din_p1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (ce) mem[wr_addr_p1] <= wdata_p1;
    end

    // Read-first RAM; the pending write is forwarded when a 1-beat line or held column reuses the address.
    always_ff @(posedge clk) begin
        if (rst) begin
            din_p1 <= '0;
            rd_p1  <= '0;
        end else if (ce) begin
            din_p1 <= din;
            rd_p1  <= (wr_addr_p1 == rd_addr_p0) ? wdata_p1 : mem[rd_addr_p0];
        end
    end

    assign taps_p1    = {rd_p1, din_p1};
    assign tap_valid  = tap_valid_p1;
    assign dout_valid = vld_p1;

`ifdef LINE_BUFFER_BORDER_REPLICATE_EN
    int top_tap;
    always_comb begin
        top_tap = 0;
        for (int k = 0; k < NUM_LINES; k++)
            if (tap_valid_p1[k]) top_tap = k;
        dout_taps = taps_p1;
        for (int k = 0; k < NUM_LINES; k++)
            if (!tap_valid_p1[k])
                dout_taps[k*DATA_WIDTH +: DATA_WIDTH] = taps_p1[top_tap*DATA_WIDTH +: DATA_WIDTH];
    end
`else
    assign dout_taps = taps_p1;
`endif
endmodule

// File: tb/tb_line_buffer_bram_xppc.sv
// Randomized bench for line_buffer_bram_xppc against a line-history reference model.
`timescale 1ns/1ps
module tb_line_buffer_bram_xppc;
    localparam int DW    = 16;
    localparam int PPC   = 4;
    localparam int MAXPX = 64;
    localparam int NL    = 3;
    localparam int DEPTH = MAXPX / PPC;

    logic clk = 1'b0;
    logic rst, ce, sof, tlast;
    logic [DW-1:0]    din;
    logic [NL*DW-1:0] dout_taps;
    logic [NL-1:0]    tap_valid;
    logic dout_valid, dout_sof, dout_tlast, ovf_err;

    int total = 0;
    int bad = 0;

    // reference model: previous lines of the frame, most recent at index 1
    logic [DW-1:0] pl [NL][DEPTH];
    int            plen [NL];
    logic [DW-1:0] cur [DEPTH];
    int curlen, m_done;
    logic m_ovf, m_bad;
    logic [DW-1:0] e_tap [NL];
    logic          e_known [NL];
    logic [NL-1:0] e_tv;
    logic e_sof, e_tlast, e_ovf;

    line_buffer_bram_xppc #(
        .DATA_WIDTH(DW), .MAX_SAMPLES_PER_CLOCK(PPC),
        .MAX_PIXELS_PER_LINE(MAXPX), .NUM_LINES(NL)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce), .sof(sof), .tlast(tlast), .din(din),
        .dout_taps(dout_taps), .tap_valid(tap_valid), .dout_valid(dout_valid),
        .dout_sof(dout_sof), .dout_tlast(dout_tlast), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_done = 0; m_ovf = 1'b0; m_bad = 1'b0; curlen = 0;
        for (int k = 0; k < NL; k++) begin
            plen[k] = 0; e_tap[k] = '0; e_known[k] = 1'b1;
        end
        e_tv = '0; e_sof = 1'b0; e_tlast = 1'b0; e_ovf = 1'b0;
    endtask

    task automatic model_beat(input logic s, input logic t, input logic [DW-1:0] d);
        int col, lf;
        logic ok;
        if (s) begin
            m_done = 0; m_ovf = 1'b0; m_bad = 1'b0; curlen = 0;
            for (int k = 0; k < NL; k++) plen[k] = 0;
        end
        col = curlen;
        lf = (m_done > NL - 1) ? NL - 1 : m_done;
        e_tv = '0;
        for (int k = 0; k < NL; k++) if (k <= lf) e_tv[k] = 1'b1;
        e_tap[0] = d; e_known[0] = 1'b1;
        for (int k = 1; k < NL; k++) begin
            ok = !m_bad && (k <= lf);
            for (int j = 1; j <= k; j++) if (col >= plen[j]) ok = 1'b0;
            e_known[k] = ok;
            e_tap[k] = '0;
            if (ok) e_tap[k] = pl[k][col];
        end
`ifdef LINE_BUFFER_BORDER_REPLICATE_EN
        for (int k = 1; k < NL; k++)
            if (k > lf) begin e_tap[k] = e_tap[lf]; e_known[k] = e_known[lf]; end
`endif
        e_sof = s; e_tlast = t;
        if (!s && !t && col >= DEPTH - 1) begin m_ovf = 1'b1; m_bad = 1'b1; end
        e_ovf = m_ovf;
        if (col < DEPTH) cur[col] = d;
        curlen++;
        if (t) begin
            for (int k = NL - 1; k >= 2; k--) begin
                plen[k] = plen[k-1];
                for (int c = 0; c < DEPTH; c++) pl[k][c] = pl[k-1][c];
            end
            plen[1] = (curlen > DEPTH) ? DEPTH : curlen;
            for (int c = 0; c < DEPTH; c++) pl[1][c] = cur[c];
            if (m_done < NL) m_done++;
            curlen = 0;
        end
    endtask

    task automatic check_outputs(input logic v);
        chk("dout_valid", 64'(dout_valid), 64'(v));
        chk("tap_valid", 64'(tap_valid), 64'(e_tv));
        chk("dout_sof", 64'(dout_sof), 64'(e_sof));
        chk("dout_tlast", 64'(dout_tlast), 64'(e_tlast));
        chk("ovf_err", 64'(ovf_err), 64'(e_ovf));
        for (int k = 0; k < NL; k++)
            if (e_known[k])
                chk($sformatf("tap%0d", k), 64'(dout_taps[k*DW +: DW]), 64'(e_tap[k]));
    endtask

    task automatic cyc(input logic c, input logic s, input logic t, input logic [DW-1:0] d);
        ce = c; sof = s; tlast = t; din = d;
        @(posedge clk); #1;
        if (rst) model_reset();
        else if (c) model_beat(s, t, d);
        check_outputs(c && !rst);
    endtask

    // one beat, optionally preceded by random ce=0 stall cycles
    task automatic beat(input logic s, input logic t, input logic [DW-1:0] d, input bit stall);
        while (stall && $urandom_range(1, 0) == 1) cyc(1'b0, 1'b0, 1'b0, DW'($urandom));
        cyc(1'b1, s, t, d);
    endtask

    task automatic send_line(input int len, input bit first, input bit stall);
        for (int c = 0; c < len; c++)
            beat(first && c == 0, c == len - 1, DW'($urandom), stall);
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; sof = 1'b0; tlast = 1'b0; din = '0;
        cyc(1'b0, 1'b0, 1'b0, '0);
        chk("reset_taps", 64'(dout_taps), 64'd0);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, '0);

        // basic fill: value = line*16 + col
        for (int l = 0; l < 4; l++)
            for (int c = 0; c < 16; c++) begin
                cyc(1'b1, l == 0 && c == 0, c == 15, DW'(l * 16 + c));
                if (l == 0 && c == 3) chk("fill_tv_l0", 64'(tap_valid), 64'(3'b001));
                if (l == 2 && c == 5) begin
                    chk("fill_l2c5", 64'(dout_taps), 64'({16'd5, 16'd21, 16'd37}));
                    chk("fill_tv_l2", 64'(tap_valid), 64'(3'b111));
                end
`ifdef LINE_BUFFER_BORDER_REPLICATE_EN
                if (l == 1 && c == 3) chk("rep_l1c3", 64'(dout_taps), 64'({16'd3, 16'd3, 16'd19}));
`else
                if (l == 1 && c == 3) chk("norep_tv_l1", 64'(tap_valid), 64'(3'b011));
`endif
            end

        // width change: 8-beat lines in a new frame
        for (int l = 0; l < 3; l++)
            for (int c = 0; c < 8; c++) begin
                cyc(1'b1, l == 0 && c == 0, c == 7, DW'(16'h100 + l * 16 + c));
                if (l == 1 && c == 7) chk("wc_tap1", 64'(dout_taps[2*DW-1:DW]), 64'(16'h107));
            end
        chk("wc_ovf", 64'(ovf_err), 64'd0);

        // overflow: 20-beat line with DEPTH=16
        for (int c = 0; c < 20; c++) begin
            cyc(1'b1, c == 0, c == 19, DW'($urandom));
            if (c == 14) chk("ovf_before", 64'(ovf_err), 64'd0);
            if (c == 15) chk("ovf_rise", 64'(ovf_err), 64'd1);
        end
        send_line(8, 1'b0, 1'b1);
        chk("ovf_sticky", 64'(ovf_err), 64'd1);
        cyc(1'b1, 1'b1, 1'b0, DW'($urandom));
        chk("ovf_clr_sof", 64'(ovf_err), 64'd0);
        send_line(15, 1'b0, 1'b0);

        // stall, then reset at line 1 col 8
        send_line(16, 1'b1, 1'b1);
        for (int c = 0; c <= 8; c++) beat(1'b0, 1'b0, DW'($urandom), 1'b1);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, '0);
        chk("rst_taps", 64'(dout_taps), 64'd0);
        chk("rst_tv", 64'(tap_valid), 64'd0);
        rst = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, DW'($urandom));
        chk("rst_next_tv", 64'(tap_valid), 64'(3'b001));
        send_line(15, 1'b0, 1'b1);
        send_line(16, 1'b0, 1'b1);
        send_line(16, 1'b0, 1'b1);

        // sof and tlast on the same beat
        cyc(1'b1, 1'b1, 1'b1, 16'hA5A5);
        cyc(1'b1, 1'b0, 1'b0, 16'h1234);
        chk("sof_tlast_tap1", 64'(dout_taps[2*DW-1:DW]), 64'(16'hA5A5));
        chk("sof_tlast_tv", 64'(tap_valid), 64'(3'b011));
        cyc(1'b1, 1'b0, 1'b1, 16'h5678);

        // random frames: random widths, stalls, occasional overflow and 1-beat lines
        for (int f = 0; f < 25; f++) begin
            int nlines;
            nlines = $urandom_range(6, 1);
            for (int l = 0; l < nlines; l++)
                send_line($urandom_range(18, 1), l == 0, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
